// File: rtl/sram_pin_pkg.sv
// Shared definitions for the SRAM pin pattern generator.
//   - Pattern mode codes (2-bit, as presented on the mode input).
//   - seed(): starting value of a lane for a given mode, truncated to the
//     lane width.
//   - Fixed levels for the transceiver and SRAM control pins while the
//     pin test runs.
package sram_pin_pkg;

  localparam logic [1:0] MODE_WALK1 = 2'd0;
  localparam logic [1:0] MODE_WALK0 = 2'd1;
  localparam logic [1:0] MODE_COUNT = 2'd2;
  localparam logic [1:0] MODE_CHECK = 2'd3;

  // Transceivers transmit towards the SRAM and are enabled; the SRAM
  // itself stays deselected with write and output-enable inactive.
  localparam logic T_R_DATA_VAL   = 1'b1;
  localparam logic T_R_ADDR_VAL   = 1'b1;
  localparam logic N_OE_TRANS_VAL = 1'b0;
  localparam logic N_WRITE_VAL    = 1'b1;
  localparam logic N_OE_VAL       = 1'b1;
  localparam logic N_CE_VAL       = 1'b1;

  // Seed value for a lane of the given width (width 1..32).
  function automatic logic [31:0] seed(input logic [1:0] mode, input int unsigned width);
    logic [31:0] mask;
    logic [31:0] raw;
    mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    case (mode)
      MODE_WALK1: raw = 32'd1;
      MODE_WALK0: raw = ~32'd1;
      MODE_COUNT: raw = 32'd0;
      default:    raw = 32'h5555_5555;
    endcase
    return raw & mask;
  endfunction

endpackage

// File: rtl/sram_pin_pattern_gen_pattern_lane.sv
// pattern_lane: one W-bit pattern register (data or address bus).
//   clk, reset_n : clock, asynchronous active-low reset (value -> 1)
//   load         : load the seed of load_mode (takes priority)
//   advance      : apply one pattern step of the current mode
//   mode         : current (registered) pattern mode
//   load_mode    : mode whose seed is loaded on load
//   value        : lane output
//   wrap_next    : the next advance will return the lane to its seed
module pattern_lane
  import sram_pin_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic         advance,
  input  logic [1:0]   mode,
  input  logic [1:0]   load_mode,
  output logic [W-1:0] value,
  output logic         wrap_next
);

  logic [W-1:0] next_value;
  logic [W-1:0] cur_seed;
  logic [W-1:0] load_seed;

  assign cur_seed  = W'(seed(mode, W));
  assign load_seed = W'(seed(load_mode, W));

  // NOTE: next_value gets a default before the case so that no path
  // leaves it unassigned; a missing default would infer a latch.
  always_comb begin
    next_value = value;
    case (mode)
      MODE_WALK1, MODE_WALK0: next_value = {value[W-2:0], value[W-1]};
      MODE_COUNT:             next_value = value + W'(1);
      default:                next_value = ~value;
    endcase
  end

  assign wrap_next = (next_value == cur_seed);

  // NOTE: state registers use non-blocking assignments so every flop
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      value <= W'(1);
    end else if (load) begin
      value <= load_seed;
    end else if (advance) begin
      value <= next_value;
    end
  end

endmodule

// File: rtl/sram_pin_pattern_gen.sv
// sram_pin_pattern_gen: board-level pin exerciser for the DS2604 SRAM bus.
// Drives data/address buses with a selectable pattern advanced once every
// PRESCALE clocks, counts completed data sweeps and holds the SRAM
// deselected with the transceivers transmitting.
//
// Ports:
//   clk, reset_n   : clock, asynchronous active-low reset
//   enable         : 1 advances prescaler/pattern, 0 freezes them
//   mode           : 0 walk-one, 1 walk-zero, 2 binary count, 3 checkerboard
//   data, addr     : bus patterns
//   led            : data[7:0], zero-extended for narrow data buses
//   step           : one-cycle strobe, high in the cycle a new pattern appears
//   sweep_cnt      : completed data sweeps (wrapping)
//   t_r_data, t_r_addr, n_oe_trans, n_write, n_oe, n_ce : fixed controls
//   data_in, err   : loopback readback and sticky mismatch flag
//
// Build option: define LOOPBACK_CHECK_EN to compare data_in with data on
// the cycle after each step; otherwise data_in is ignored and err is 0.
module sram_pin_pattern_gen
  import sram_pin_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 15,
  parameter int PRESCALE = 524288,
  parameter int SWEEP_W  = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               enable,
  input  logic [1:0]         mode,
  output logic [DATA_W-1:0]  data,
  output logic [ADDR_W-1:0]  addr,
  output logic [7:0]         led,
  output logic               step,
  output logic [SWEEP_W-1:0] sweep_cnt,
  output logic               t_r_data,
  output logic               t_r_addr,
  output logic               n_oe_trans,
  output logic               n_write,
  output logic               n_oe,
  output logic               n_ce,
  input  logic [DATA_W-1:0]  data_in,
  output logic               err
);

  localparam int PS_W = $clog2(PRESCALE);
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0] prescaler;
  logic [1:0]      mode_q;
  logic            mode_change;
  logic            tick;
  logic            data_wrap;
  logic            unused_addr_wrap;

  // A mode change reloads the seeds and restarts the prescaler; it wins
  // over a step falling on the same edge.
  assign mode_change = (mode != mode_q);
  assign tick        = enable && !mode_change && (prescaler == PS_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prescaler <= '0;
      mode_q    <= MODE_WALK1;
      step      <= 1'b0;
      sweep_cnt <= '0;
    end else begin
      step <= tick;
      if (mode_change) begin
        mode_q    <= mode;
        prescaler <= '0;
      end else if (enable) begin
        prescaler <= tick ? '0 : prescaler + PS_W'(1);
      end
      if (tick && data_wrap) begin
        sweep_cnt <= sweep_cnt + SWEEP_W'(1);
      end
    end
  end

  pattern_lane #(.W(DATA_W)) u_data_lane (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (mode_change),
    .advance   (tick),
    .mode      (mode_q),
    .load_mode (mode),
    .value     (data),
    .wrap_next (data_wrap)
  );

  pattern_lane #(.W(ADDR_W)) u_addr_lane (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (mode_change),
    .advance   (tick),
    .mode      (mode_q),
    .load_mode (mode),
    .value     (addr),
    .wrap_next (unused_addr_wrap)
  );

  generate
    if (DATA_W >= 8) begin : g_led_wide
      assign led = data[7:0];
    end else begin : g_led_narrow
      assign led = {{(8 - DATA_W){1'b0}}, data};
    end
  endgenerate

  assign t_r_data   = T_R_DATA_VAL;
  assign t_r_addr   = T_R_ADDR_VAL;
  assign n_oe_trans = N_OE_TRANS_VAL;
  assign n_write    = N_WRITE_VAL;
  assign n_oe       = N_OE_VAL;
  assign n_ce       = N_CE_VAL;

`ifdef LOOPBACK_CHECK_EN
  logic [DATA_W-1:0] data_in_q;
  logic              check_q;

  // data_in_q captures the bus during the step cycle; the comparison runs
  // one cycle later. A mode change at the end of the step cycle moves data
  // away from what was captured, so that comparison is skipped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_in_q <= '0;
      check_q   <= 1'b0;
      err       <= 1'b0;
    end else begin
      data_in_q <= data_in;
      check_q   <= step && !mode_change;
      if (check_q && (data_in_q != data)) begin
        err <= 1'b1;
      end
    end
  end
`else
  logic unused_data_in;
  assign unused_data_in = ^data_in;
  assign err = 1'b0;
`endif

endmodule
